// File: rtl/multisim_client_pull_mc_if.sv
// ---------------------------------------------------------------------------
// multisim_client_pull_mc_if
//   Per-channel valid/ready delivery bus between the multi-channel multisim
//   pull client and its consumers.
//
//   data_rdy [NUM_CHANNELS]              consumer ready per channel
//   data_vld [NUM_CHANNELS]              head-of-FIFO valid per channel
//   data     [NUM_CHANNELS][DATA_WIDTH]  head-of-FIFO payload per channel
//
//   master : the client (drives data_vld/data, samples data_rdy)
//   slave  : the consumer side
// ---------------------------------------------------------------------------
interface multisim_client_pull_mc_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 64
) ();
  logic [NUM_CHANNELS-1:0]                 data_rdy;
  logic [NUM_CHANNELS-1:0]                 data_vld;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] data;

  modport master (output data_vld, output data, input data_rdy);
  modport slave  (input data_vld, input data, output data_rdy);
endinterface

// File: rtl/multisim_client_pull_mc.sv
// ---------------------------------------------------------------------------
// multisim_client_pull_mc
//   Multi-channel multisim pull client. NUM_CHANNELS server streams share one
//   pull call per cycle, granted round-robin. Each channel owns a FIFO_DEPTH
//   prefetch FIFO and an empty-poll backoff timer that keeps idle servers from
//   being hammered.
//
// Ports
//   clk          simulation clock, all state on posedge
//   rst          asynchronous, active-high reset
//   server_name  per-channel server name, static from time 0
//   bus          multisim_client_pull_mc_if.master (data_rdy/data_vld/data)
//   pull_ok_cnt, pull_empty_cnt   per-channel pull counters (stats build only)
//
// Build macros
//   MULTISIM_CLIENT_PULL_MC_STATS_EN  adds the pull counters and a $final
//                                     per-channel report.
//
//   The pull/start calls are served by a queue-backed SV server model.
// ---------------------------------------------------------------------------
package multisim_pkg;
  localparam int MULTISIM_MAX_WIDTH = 256;

  // Server model: one queue per registered server name. Every pull is logged
  // so client-side traffic can be observed.
  localparam int MODEL_MAX_SERVERS = 16;

  bit [MULTISIM_MAX_WIDTH-1:0] srv_q [MODEL_MAX_SERVERS][$];
  int                          pull_calls [MODEL_MAX_SERVERS];
  int                          pull_log [$];
  int                          name_idx [string];
  int                          num_servers = 0;

  function automatic int model_idx(input string name);
    if (!name_idx.exists(name)) begin
      name_idx[name] = num_servers;
      num_servers++;
    end
    return name_idx[name];
  endfunction

  function automatic void multisim_client_start(
    input string server_runtime_directory, input string server_name);
    if (server_runtime_directory.len() >= 0) void'(model_idx(server_name));
  endfunction

  function automatic int multisim_client_pull_packed(
    input string server_name, output bit [MULTISIM_MAX_WIDTH-1:0] data,
    input int data_width);
    int idx = model_idx(server_name);
    data = '0;
    pull_calls[idx]++;
    pull_log.push_back(idx);
    if (srv_q[idx].size() == 0) return 0;
    data = srv_q[idx].pop_front();
    if (data_width < MULTISIM_MAX_WIDTH)
      data &= (MULTISIM_MAX_WIDTH'(1) << data_width) - 1'b1;
    return 1;
  endfunction
endpackage

module multisim_client_pull_mc #(
  parameter string SERVER_RUNTIME_DIRECTORY = "../output_top",
  parameter int    DATA_WIDTH               = 64,
  parameter int    NUM_CHANNELS             = 4,
  parameter int    FIFO_DEPTH               = 4,
  parameter int    POLL_BACKOFF             = 8
) (
  input  logic  clk,
  input  logic  rst,
  input  string server_name [NUM_CHANNELS],
  multisim_client_pull_mc_if.master bus
`ifdef MULTISIM_CLIENT_PULL_MC_STATS_EN
  ,
  output logic [NUM_CHANNELS-1:0][31:0] pull_ok_cnt,
  output logic [NUM_CHANNELS-1:0][31:0] pull_empty_cnt
`endif
);
  import multisim_pkg::*;

  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int RR_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int BO_W  = (POLL_BACKOFF > 0) ? $clog2(POLL_BACKOFF + 1) : 1;
  localparam logic [BO_W-1:0] BO_RELOAD = BO_W'(POLL_BACKOFF);

  logic [DATA_WIDTH-1:0]                   mem     [NUM_CHANNELS][FIFO_DEPTH];
  logic [PTR_W-1:0]                        rd_ptr  [NUM_CHANNELS];
  logic [PTR_W-1:0]                        wr_ptr  [NUM_CHANNELS];
  logic [OCC_W-1:0]                        occ     [NUM_CHANNELS];
  logic [BO_W-1:0]                         backoff [NUM_CHANNELS];
  logic [RR_W-1:0]                         rr_ptr;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] head_q;

  logic [NUM_CHANNELS-1:0] eligible;
  logic [NUM_CHANNELS-1:0] pop;
  logic                    grant_vld;
  logic [RR_W-1:0]         grant_idx;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Eligibility uses start-of-cycle occupancy, so a full channel that is
  // being popped this cycle still waits one more cycle for a pull.
  always_comb begin
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      eligible[i]     = (occ[i] < OCC_W'(FIFO_DEPTH)) && (backoff[i] == '0);
      pop[i]          = (occ[i] != '0) && bus.data_rdy[i];
      bus.data_vld[i] = (occ[i] != '0);
    end
  end

  assign bus.data = head_q;

  // Scan from the far end back toward rr_ptr so the last hit is the first
  // eligible channel at or above the pointer (with wrap).
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = rr_ptr;
    for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
      int c;
      c = int'(rr_ptr) + k;
      if (c >= NUM_CHANNELS) c -= NUM_CHANNELS;
      if (eligible[c]) begin
        grant_vld = 1'b1;
        grant_idx = RR_W'(c);
      end
    end
  end

  // NOTE: the prefetch storage is not reset; occupancy alone decides what is
  // valid, and the head register is what appears on the outputs.
  always_ff @(posedge clk or posedge rst) begin : seq
    int                          pull_ret;
    bit [MULTISIM_MAX_WIDTH-1:0] pull_buf;
    logic                        pull_ok;
    logic [DATA_WIDTH-1:0]       pull_data;
    logic                        push_i;
    logic                        empty_i;
    if (rst) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        rd_ptr[i]  <= '0;
        wr_ptr[i]  <= '0;
        occ[i]     <= '0;
        backoff[i] <= '0;
        head_q[i]  <= '0;
`ifdef MULTISIM_CLIENT_PULL_MC_STATS_EN
        pull_ok_cnt[i]    <= '0;
        pull_empty_cnt[i] <= '0;
`endif
      end
      rr_ptr <= '0;
    end else begin
      // NOTE: pull_* / push_i / empty_i are block-local temporaries carrying
      // the pull result within this edge, hence blocking; all state uses <=.
      pull_ok  = 1'b0;
      pull_buf = '0;
      if (grant_vld) begin
        pull_ret = multisim_client_pull_packed(server_name[grant_idx], pull_buf, DATA_WIDTH);
        pull_ok  = pull_ret[0];
        rr_ptr  <= (int'(grant_idx) == NUM_CHANNELS - 1) ? '0 : grant_idx + 1'b1;
      end
      pull_data = pull_buf[DATA_WIDTH-1:0];

      for (int i = 0; i < NUM_CHANNELS; i++) begin
        push_i  = grant_vld && pull_ok && (int'(grant_idx) == i);
        empty_i = grant_vld && !pull_ok && (int'(grant_idx) == i);

        if (push_i) begin
          mem[i][wr_ptr[i]] <= pull_data;
          wr_ptr[i]         <= ptr_inc(wr_ptr[i]);
        end
        if (pop[i]) rd_ptr[i] <= ptr_inc(rd_ptr[i]);
        occ[i] <= occ[i] + OCC_W'(push_i) - OCC_W'(pop[i]);

        // Head register follows the FIFO: next stored entry on a pop, or the
        // freshly pulled word when it lands in an empty (or emptying) FIFO.
        if (pop[i]) begin
          if (occ[i] > OCC_W'(1)) head_q[i] <= mem[i][ptr_inc(rd_ptr[i])];
          else if (push_i)        head_q[i] <= pull_data;
        end else if ((occ[i] == '0) && push_i) begin
          head_q[i] <= pull_data;
        end

        if (empty_i)                backoff[i] <= BO_RELOAD;
        else if (backoff[i] != '0)  backoff[i] <= backoff[i] - 1'b1;

`ifdef MULTISIM_CLIENT_PULL_MC_STATS_EN
        if (push_i)  pull_ok_cnt[i]    <= pull_ok_cnt[i] + 32'd1;
        if (empty_i) pull_empty_cnt[i] <= pull_empty_cnt[i] + 32'd1;
`endif
      end
    end
  end

`ifndef SYNTHESIS
  initial begin
    for (int i = 0; i < NUM_CHANNELS; i++)
      multisim_client_start(SERVER_RUNTIME_DIRECTORY, server_name[i]);
  end
`ifdef MULTISIM_CLIENT_PULL_MC_STATS_EN
  final begin
    for (int i = 0; i < NUM_CHANNELS; i++)
      $display("multisim_client_pull_mc %s: pull_ok=%0d pull_empty=%0d",
               server_name[i], pull_ok_cnt[i], pull_empty_cnt[i]);
  end
`endif
`endif
endmodule

// File: tb/tb_multisim_client_pull_mc.sv
// ---------------------------------------------------------------------------
// tb_multisim_client_pull_mc
//   Directed bench for multisim_client_pull_mc with 4 channels, 64-bit data,
//   FIFO_DEPTH 4, POLL_BACKOFF 8. Server contents are loaded straight into
//   the SV server model; the model's pull log gives the grant order.
// ---------------------------------------------------------------------------
module tb_multisim_client_pull_mc;
  import multisim_pkg::*;

  localparam int NC = 4;
  localparam int DW = 64;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  string server_name [NC] = '{"srv0", "srv1", "srv2", "srv3"};
  int    sidx [NC];
  int    n_checks = 0;
  int    n_fail   = 0;

  multisim_client_pull_mc_if #(.NUM_CHANNELS(NC), .DATA_WIDTH(DW)) bus ();

`ifdef MULTISIM_CLIENT_PULL_MC_STATS_EN
  logic [NC-1:0][31:0] pull_ok_cnt;
  logic [NC-1:0][31:0] pull_empty_cnt;
`endif

  multisim_client_pull_mc #(
    .SERVER_RUNTIME_DIRECTORY("../output_top"),
    .DATA_WIDTH(DW), .NUM_CHANNELS(NC), .FIFO_DEPTH(4), .POLL_BACKOFF(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .server_name(server_name),
    .bus(bus)
`ifdef MULTISIM_CLIENT_PULL_MC_STATS_EN
    ,
    .pull_ok_cnt(pull_ok_cnt),
    .pull_empty_cnt(pull_empty_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load(input int ch, input int base, input int n);
    for (int k = 1; k <= n; k++)
      srv_q[sidx[ch]].push_back(MULTISIM_MAX_WIDTH'(base + k));
  endtask

  task automatic clear_servers();
    for (int i = 0; i < NC; i++) srv_q[sidx[i]].delete();
  endtask

  // Called at a negedge; returns at a negedge with rst released.
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    pull_log.delete();
  endtask

  initial begin
    int exp_next [NC];
    int pops     [NC];
    int exp_bo   [13] = '{0, 1, 2, 3, 0, 1, 3, 0, 1, 3, 0, 1, 2};
    int exp_mid  [6]  = '{0, 1, 2, 3, 1, 1};
    int n2;

    for (int i = 0; i < NC; i++) sidx[i] = model_idx(server_name[i]);
    bus.data_rdy = '0;

    // ---- Reset with servers holding data --------------------------------
    load(0, 'h00, 10);
    load(1, 'h10, 8);
    load(2, 'h20, 8);
    load(3, 'h30, 8);
    repeat (5) @(negedge clk);
    check("rst_vld", bus.data_vld, 4'b0000);
    check("rst_data", bus.data, 0);
    check("rst_no_pulls", pull_log.size(), 0);
    rst = 1'b0;
    tick();
    check("first_pull_count", pull_log.size(), 1);
    check("first_grant", pull_log[0], 0);
    check("first_vld", bus.data_vld, 4'b0001);
    check("first_data0", bus.data[0], 'h1);

    // ---- Back-pressure: all FIFOs fill, round-robin fill order ---------
    repeat (20) tick();
    check("bp_pulls_ch0", pull_calls[sidx[0]], 4);
    check("bp_total_pulls", pull_log.size(), 16);
    for (int k = 0; k < 16; k++)
      check($sformatf("fill_grant_%0d", k), pull_log[k], k % 4);
    check("bp_vld", bus.data_vld, 4'b1111);
    check("bp_head0", bus.data[0], 'h1);
    check("bp_head1", bus.data[1], 'h11);
    check("bp_head2", bus.data[2], 'h21);
    check("bp_head3", bus.data[3], 'h31);

    // ---- Ordering: drain channel 0 --------------------------------------
    pull_log.delete();
    bus.data_rdy = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("ord_vld_%0d", k), bus.data_vld[0], 1'b1);
      check($sformatf("ord_data_%0d", k), bus.data[0], k + 1);
      tick();
    end
    check("ord_drained", bus.data_vld[0], 1'b0);
    check("ord_pulls", pull_log.size(), 7);

    // ---- Round-robin fairness -------------------------------------------
    clear_servers();
    for (int i = 0; i < NC; i++) begin
      load(i, i << 8, 20);
      exp_next[i] = (i << 8) + 1;
      pops[i] = 0;
    end
    bus.data_rdy = 4'b1111;
    do_reset();
    repeat (16) begin
      tick();
      for (int i = 0; i < NC; i++) begin
        if (bus.data_vld[i]) begin
          check($sformatf("rr_data_ch%0d", i), bus.data[i], exp_next[i]);
          exp_next[i]++;
          pops[i]++;
        end
      end
    end
    for (int i = 0; i < NC; i++)
      check($sformatf("rr_items_ch%0d", i), pops[i], 4);
    for (int k = 0; k < 16; k++)
      check($sformatf("rr_grant_%0d", k), pull_log[k], k % 4);

    // ---- Backoff on channel 2 -------------------------------------------
    clear_servers();
    load(0, 'h400, 20);
    load(1, 'h500, 20);
    load(3, 'h700, 20);
    do_reset();
    repeat (5) tick();
    srv_q[sidx[2]].push_back(MULTISIM_MAX_WIDTH'('h2A));
    repeat (7) tick();
    n2 = 0;
    for (int k = 0; k < pull_log.size(); k++) if (pull_log[k] == 2) n2++;
    check("bo_ch2_polls_before", n2, 1);
    tick();
    check("bo_total_pulls", pull_log.size(), 13);
    for (int k = 0; k < 13; k++)
      check($sformatf("bo_grant_%0d", k), pull_log[k], exp_bo[k]);
    check("bo_vld2", bus.data_vld[2], 1'b1);
    check("bo_data2", bus.data[2], 'h2A);

    // ---- Reset mid-operation --------------------------------------------
    clear_servers();
    load(1, 'h50, 8);
    bus.data_rdy = 4'b0000;
    do_reset();
    repeat (6) tick();
    check("mid_pulls", pull_log.size(), 6);
    for (int k = 0; k < 6; k++)
      check($sformatf("mid_grant_%0d", k), pull_log[k], exp_mid[k]);
    check("mid_vld", bus.data_vld, 4'b0010);
    check("mid_head1", bus.data[1], 'h51);
    #2 rst = 1'b1;
    #1;
    check("mid_async_vld", bus.data_vld, 4'b0000);
    check("mid_async_data", bus.data, 0);
    @(negedge clk);
    rst = 1'b0;
    check("mid_no_pull_in_rst", pull_log.size(), 6);
    tick();
    tick();
    check("mid_after_pulls", pull_log.size(), 8);
    check("mid_after_grant", pull_log[7], 1);
    check("mid_after_vld1", bus.data_vld[1], 1'b1);
    check("mid_after_data1", bus.data[1], 'h54);

`ifdef MULTISIM_CLIENT_PULL_MC_STATS_EN
    // ---- Statistics counters --------------------------------------------
    clear_servers();
    load(3, 'h60, 5);
    bus.data_rdy = 4'b1111;
    do_reset();
    check("st_ok3_after_rst", pull_ok_cnt[3], 0);
    repeat (20) tick();
    check("st_ok3", pull_ok_cnt[3], 5);
    check("st_empty3", pull_empty_cnt[3], 2);
    check("st_empty0", pull_empty_cnt[0], 3);
    check("st_ok0", pull_ok_cnt[0], 0);
    #2 rst = 1'b1;
    #1;
    check("st_ok3_rst", pull_ok_cnt[3], 0);
    check("st_empty3_rst", pull_empty_cnt[3], 0);
    @(negedge clk);
    rst = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/multisim_client_pull_mc.md
Name: multisim_client_pull_mc

Overview:
- Multi-channel successor to the single-channel multisim pull client.
- Serves NUM_CHANNELS independent server streams, one DPI pull (multisim_client_pull_packed) per cycle at most, shared round-robin across channels.
- Each channel has a FIFO_DEPTH prefetch FIFO decoupling consumer stalls from server polling, plus a per-channel empty-poll backoff timer that limits DPI traffic on idle servers.
- Sits between multisim server endpoints and client-side RTL consumers with a valid/ready interface.

Parameters:
- SERVER_RUNTIME_DIRECTORY, "../output_top": server runtime directory passed to multisim_client_start.
- DATA_WIDTH, 64: payload width per channel, >=1.
- NUM_CHANNELS, 4: number of independent streams, >=1.
- FIFO_DEPTH, 4: prefetch entries per channel, >=1.
- POLL_BACKOFF, 8: idle cycles after an empty pull before that channel may be polled again. 0 = no backoff.

Ports:
- clk  input  1  simulation clock, all state on posedge.
- rst  input  1  asynchronous, active-high reset.
- server_name  input  string[NUM_CHANNELS]  per-channel server name, static from time 0.
- data_rdy  input  [NUM_CHANNELS-1:0]  consumer ready per channel.
- data_vld  output  [NUM_CHANNELS-1:0]  per-channel head-of-FIFO valid.
- data  output  [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]  per-channel head-of-FIFO payload.

Behaviour:
- Startup: an initial block calls multisim_client_start(SERVER_RUNTIME_DIRECTORY, server_name[i]) for every channel i, at time 0.
- Reset (async assert, sync release on clk), while rst=1:
  - data_vld=0, data=0.
  - All FIFOs empty; all backoff counters 0; round-robin pointer = 0.
  - No DPI pull calls are issued.
  - Asserting rst mid-operation discards all prefetched entries; this data is lost by design.
- FIFO per channel:
  - data_vld[i] = FIFO non-empty; data[i] = head entry, registered.
  - Pop when data_vld[i] && data_rdy[i] at posedge.
  - Order is strictly preserved per channel.
- Eligibility of channel i in a cycle:
  - occupancy at start of the cycle < FIFO_DEPTH, and
  - backoff[i] == 0.
  - A same-cycle pop does not make a full channel eligible.
- Arbitration:
  - Choose the first eligible channel scanning from the RR pointer upward, with wrap-around.
  - When a channel is polled, the pointer moves to (granted+1) mod NUM_CHANNELS.
  - With no eligible channel, no pull is issued and the pointer holds.
- Pull: one call of multisim_client_pull_packed(server_name[g], tmp, DATA_WIDTH) per posedge for granted channel g.
  - Return bit0=1: push tmp into FIFO g. Visible on data[g]/data_vld[g] after the same edge, i.e. 1-cycle latency from eligibility on an empty FIFO.
  - Return bit0=0: no push; backoff[g] <= POLL_BACKOFF.
- Simultaneous push and pop on one channel: occupancy unchanged; the head advances correctly, including the single-entry case where the pushed item becomes the head.
- Backoff: each nonzero counter decrements by 1 per cycle and saturates at 0.
- Pointers: FIFO read/write pointers wrap modulo FIFO_DEPTH. Occupancy counter width is $clog2(FIFO_DEPTH+1).

Optional Feature:
- Macro: MULTISIM_CLIENT_PULL_MC_STATS_EN.
- Defined: adds output ports pull_ok_cnt and pull_empty_cnt, each [NUM_CHANNELS-1:0][31:0].
  - Per channel, they count successful and empty DPI pulls respectively.
  - Both reset to 0 and wrap at 2^32.
  - At $final, the block $display's each channel's server_name with both counts.
- Undefined: these ports, the counters and the report do not exist; all other behaviour is identical.

Test Plan:
- Reset behaviour: rst=1 for 5 cycles with servers holding data -> data_vld=0, data=0, zero DPI calls. After release, first pull goes to channel 0.
- Ordering and back-pressure: channel 0 server sends 0x1..0xA, data_rdy[0] held 0 -> exactly 4 pulls (FIFO_DEPTH) and data[0]=0x1 held. Then data_rdy[0]=1 -> 0x1..0xA delivered in order, one per cycle once steady.
- Round-robin fairness: all 4 channels always have data, all rdy=1 -> pull grant sequence 0,1,2,3,0,… with each channel receiving one item per 4 cycles.
- Backoff: channel 2 server empty -> polled once, then not again for 8 cycles. Data made available at cycle 3 of the backoff -> next pull occurs only after the counter reaches 0; other channels' grants are unaffected.
- Reset mid-operation: channel 1 FIFO holding 3 entries, rst pulsed for 1 cycle between edges -> data_vld goes 0 immediately (async), entries discarded, the next pulled item is the server's next item.
- Stats (macro on): channel 3 gets 5 ok and 2 empty pulls -> pull_ok_cnt[3]=5, pull_empty_cnt[3]=2. rst -> both return to 0.
